// File: rtl/finn_feeder_21b_16_hls_axis_block_detector_if.sv
// Report handshake bundle of the AXIS block detector.
// master: report_valid/idx/count out, report_ready in; slave: reverse.
interface finn_feeder_21b_16_hls_axis_block_detector_if #(
  parameter int IDX_W = 4
);
  logic             report_valid;
  logic             report_ready;
  logic [IDX_W-1:0] report_idx;
  logic [7:0]       report_count;

  modport master (
    output report_valid,
    output report_idx,
    output report_count,
    input  report_ready
  );

  modport slave (
    input  report_valid,
    input  report_idx,
    input  report_count,
    output report_ready
  );
endinterface

// File: rtl/finn_feeder_21b_16_hls_axis_block_detector.sv
// Per-channel AXIS stall counters with a sticky blocking-event reporter.
// Ports: clock, reset, enable, ch_tvalid/ch_tready in, axis_block_sigs out,
// report (master modport: report_valid/idx/count out, report_ready in).
module finn_feeder_21b_16_hls_axis_block_detector #(
  parameter int N_CH   = 2,
  parameter int THRESH = 1024,
  parameter int CNT_W  = 16,
  parameter int IDX_W  = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic [N_CH-1:0] ch_tvalid,
  input  logic [N_CH-1:0] ch_tready,
  output logic [N_CH-1:0] axis_block_sigs,
  finn_feeder_21b_16_hls_axis_block_detector_if.master report
);

  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESH);

  typedef enum logic [1:0] {
    IDLE,
    REPORT,
    HOLD
  } state_t;

  state_t           state;
  logic             rep_valid;
  logic [IDX_W-1:0] rep_idx;
  logic [7:0]       rep_count;

  // One side waiting with no transfer happening.
  logic [N_CH-1:0] stall;
  assign stall = ch_tvalid ^ ch_tready;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock) begin
      if (reset) begin
        cnt <= '0;
      end else if (!enable || !stall[i]) begin
        cnt <= '0;
      end else if (cnt != THR) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign axis_block_sigs[i] = (cnt == THR);
  end

  function automatic logic [IDX_W-1:0] lowest(
    input logic [N_CH-1:0] v
  );
    lowest = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (v[i]) lowest = IDX_W'(i);
    end
  endfunction

  // HOLD waits for every block to clear so one
  // blocking episode yields exactly one report.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      rep_valid <= 1'b0;
      rep_idx   <= '0;
      rep_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|axis_block_sigs) begin
            rep_idx   <= lowest(axis_block_sigs);
            rep_valid <= 1'b1;
            state     <= REPORT;
          end
        end
        REPORT: begin
          if (report.report_ready) begin
            rep_valid <= 1'b0;
            if (rep_count != 8'hFF) rep_count <= rep_count + 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (~|axis_block_sigs) state <= IDLE;
        end
        default: begin
          rep_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign report.report_valid = rep_valid;
  assign report.report_idx   = rep_idx;
  assign report.report_count = rep_count;

endmodule

// File: tb/tb_finn_feeder_21b_16_hls_axis_block_detector.sv
// Randomized and directed bench for the AXIS block detector.
// Compares every cycle against an event-level reference model.
module tb_finn_feeder_21b_16_hls_axis_block_detector;

  localparam int N_CH   = 2;
  localparam int THRESH = 4;

  logic            clock;
  logic            reset;
  logic            enable;
  logic [N_CH-1:0] ch_tvalid;
  logic [N_CH-1:0] ch_tready;
  logic [N_CH-1:0] axis_block_sigs;

  finn_feeder_21b_16_hls_axis_block_detector_if #(.IDX_W(4)) rep ();

  finn_feeder_21b_16_hls_axis_block_detector #(
    .N_CH(N_CH),
    .THRESH(THRESH),
    .CNT_W(16),
    .IDX_W(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .ch_tvalid(ch_tvalid),
    .ch_tready(ch_tready),
    .axis_block_sigs(axis_block_sigs),
    .report(rep)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Model: run length of consecutive stalled edges per channel,
  // plus "event outstanding" and "armed for a new event" flags.
  int run [N_CH];
  bit pend;
  bit armed;
  int m_idx;
  int m_cnt;
  bit saw_valid;

  function automatic bit blocked(input int i);
    return run[i] >= THRESH;
  endfunction

  task automatic model_edge();
    bit any_old;
    int low;
    any_old = 0;
    low = 0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (blocked(i)) begin
        any_old = 1;
        low = i;
      end
    end
    if (reset) begin
      for (int i = 0; i < N_CH; i++) run[i] = 0;
      pend  = 0;
      armed = 1;
      m_idx = 0;
      m_cnt = 0;
    end else begin
      if (pend) begin
        if (rep.report_ready) begin
          pend = 0;
          if (m_cnt < 255) m_cnt++;
        end
      end else if (armed) begin
        if (any_old) begin
          pend  = 1;
          armed = 0;
          m_idx = low;
        end
      end else if (!any_old) begin
        armed = 1;
      end
      for (int i = 0; i < N_CH; i++) begin
        if (enable && (ch_tvalid[i] != ch_tready[i])) run[i]++;
        else run[i] = 0;
      end
    end
  endtask

  task automatic step();
    logic [N_CH-1:0] eb;
    @(posedge clock);
    model_edge();
    #1;
    for (int i = 0; i < N_CH; i++) eb[i] = blocked(i);
    check("block", 32'(axis_block_sigs), 32'(eb));
    check("valid", 32'(rep.report_valid), 32'(pend));
    if (pend) check("idx", 32'(rep.report_idx), 32'(m_idx));
    check("count", 32'(rep.report_count), 32'(m_cnt));
    if (rep.report_valid) saw_valid = 1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  logic [1:0] pr [N_CH];

  initial begin
    for (int i = 0; i < N_CH; i++) run[i] = 0;
    pend  = 0;
    armed = 1;
    m_idx = 0;
    m_cnt = 0;
    saw_valid = 0;
    reset = 1'b1;
    enable = 1'b1;
    ch_tvalid = '0;
    ch_tready = '0;
    rep.report_ready = 1'b0;
    steps(2);
    check("rst_blk", 32'(axis_block_sigs), 32'd0);
    check("rst_vld", 32'(rep.report_valid), 32'd0);
    check("rst_idx", 32'(rep.report_idx), 32'd0);
    check("rst_cnt", 32'(rep.report_count), 32'd0);
    reset = 1'b0;
    steps(1);

    // Single channel stall: block after 4th edge, report one later.
    ch_tvalid = 2'b01;
    steps(3);
    check("pre_blk", 32'(axis_block_sigs), 32'd0);
    steps(1);
    check("blk4", 32'(axis_block_sigs), 32'd1);
    check("nv4", 32'(rep.report_valid), 32'd0);
    steps(1);
    check("rv5", 32'(rep.report_valid), 32'd1);
    check("ri5", 32'(rep.report_idx), 32'd0);
    steps(1);
    rep.report_ready = 1'b1;
    ch_tvalid = 2'b00;
    steps(1);
    check("acc1", 32'(rep.report_count), 32'd1);
    rep.report_ready = 1'b0;
    steps(2);

    // Stall interrupted by a transfer never blocks.
    saw_valid = 0;
    ch_tvalid = 2'b10;
    steps(3);
    ch_tready = 2'b10;
    steps(1);
    ch_tready = 2'b00;
    steps(3);
    ch_tvalid = 2'b00;
    steps(2);
    check("no_blk_rep", 32'(saw_valid), 32'd0);

    // Both channels stall together: one report, lowest index.
    reset = 1'b1;
    steps(1);
    reset = 1'b0;
    ch_tready = 2'b11;
    steps(4);
    check("both_blk", 32'(axis_block_sigs), 32'd3);
    steps(1);
    check("both_idx", 32'(rep.report_idx), 32'd0);
    rep.report_ready = 1'b1;
    steps(1);
    rep.report_ready = 1'b0;
    steps(3);
    check("both_cnt", 32'(rep.report_count), 32'd1);
    check("both_one", 32'(rep.report_valid), 32'd0);

    // Stall removed before acceptance: report is sticky.
    ch_tready = 2'b00;
    steps(2);
    ch_tvalid = 2'b10;
    steps(5);
    ch_tvalid = 2'b00;
    steps(5);
    check("sticky", 32'(rep.report_valid), 32'd1);
    check("sticky_idx", 32'(rep.report_idx), 32'd1);
    rep.report_ready = 1'b1;
    steps(1);
    rep.report_ready = 1'b0;
    steps(1);
    check("sticky_cnt", 32'(rep.report_count), 32'd2);

    // Reset while a report is pending.
    ch_tvalid = 2'b01;
    steps(5);
    check("pre_rst_v", 32'(rep.report_valid), 32'd1);
    reset = 1'b1;
    steps(1);
    reset = 1'b0;
    check("rst_v", 32'(rep.report_valid), 32'd0);
    check("rst_c", 32'(rep.report_count), 32'd0);
    check("rst_b", 32'(axis_block_sigs), 32'd0);
    ch_tvalid = 2'b00;
    steps(2);

    // Saturation of the accepted-report counter.
    rep.report_ready = 1'b1;
    for (int k = 0; k < 257; k++) begin
      ch_tvalid = 2'b01;
      steps(6);
      ch_tvalid = 2'b00;
      steps(2);
    end
    check("sat", 32'(rep.report_count), 32'd255);
    rep.report_ready = 1'b0;

    // Randomized traffic with sticky per-channel stall patterns.
    reset = 1'b1;
    steps(1);
    reset = 1'b0;
    for (int i = 0; i < N_CH; i++) pr[i] = 2'b00;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N_CH; i++) begin
        if ($urandom_range(99) < 15) pr[i] = 2'($urandom_range(3));
        ch_tvalid[i] = pr[i][0];
        ch_tready[i] = pr[i][1];
      end
      enable = ($urandom_range(99) < 97);
      rep.report_ready = ($urandom_range(99) < 30);
      reset = ($urandom_range(999) < 3);
      steps(1);
    end
    reset = 1'b0;
    enable = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/finn_feeder_21b_16_hls_axis_block_detector.md
FINN_FEEDER_21B_16_HLS_AXIS_BLOCK_DETECTOR -- requirements
Module: finn_feeder_21b_16_hls_axis_block_detector

Interface
REQ-001 Parameter N_CH, default 2: number of observed AXIS channels; legal range 1..16.
REQ-002 Parameter THRESH, default 1024: consecutive stall cycles before a channel is declared blocked; legal range 1..2^CNT_W-1.
REQ-003 Parameter CNT_W, default 16: stall-counter width per channel.
REQ-004 Parameter IDX_W, default 4: width of report_idx; SHALL satisfy 2^IDX_W >= N_CH.
REQ-005 Clocking is one clock; reset is synchronous and active-high. Port clock, input, 1: rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 enable  input  1  detection enable; 0 clears and freezes detection.
REQ-008 ch_tvalid  input  N_CH  per-channel observed TVALID.
REQ-009 ch_tready  input  N_CH  per-channel observed TREADY.
REQ-010 axis_block_sigs  output  N_CH  per-channel blocked flag; feeds the deadlock monitor's axis_block_sigs input.
REQ-011 report_valid  output  1  a new blocking event is being reported.
REQ-012 report_ready  input  1  report consumer acceptance.
REQ-013 report_idx  output  IDX_W  index of the reported channel.
REQ-014 report_count  output  8  number of reports accepted since reset, saturating.

Function
REQ-015 Channel i stall condition SHALL be ch_tvalid[i] XOR ch_tready[i] (one side waiting, no transfer).
REQ-016 Per-channel counter cnt[i] SHALL: clear to 0 on any edge where stall[i]=0 or enable=0; else increment by 1, saturating at THRESH.
REQ-017 axis_block_sigs[i] SHALL be 1 exactly when cnt[i]==THRESH (driven from registered state, no combinational path from ch_* inputs).
REQ-018 Latency: block asserts after THRESH consecutive edges sampling stall[i]=1; deasserts after the first edge sampling stall[i]=0.
REQ-019 A transfer (tvalid=tready=1) or idle (both 0) SHALL clear the counter, even for one cycle.
REQ-020 Report FSM states IDLE, REPORT, HOLD; reset state IDLE.
REQ-021 IDLE: if any axis_block_sigs bit is 1, capture lowest set index into report_idx, go REPORT.
REQ-022 REPORT: report_valid=1; report_idx stable; on report_ready=1 go HOLD and increment report_count (saturate at 255).
REQ-023 REPORT: if all block bits clear before acceptance, report SHALL still remain valid until accepted (event is sticky).
REQ-024 HOLD: report_valid=0; go IDLE on the first edge where all axis_block_sigs bits are 0.
REQ-025 Simultaneous block assertion on several channels: lowest index reported; others produce no further report until HOLD returns to IDLE.
REQ-026 report_valid SHALL be 0 in IDLE and HOLD; report_ready ignored outside REPORT.
REQ-027 enable=0 mid-report: counters clear, blocks drop; FSM continues per REQ-022..024.

Reset
REQ-028 On reset: all cnt=0, axis_block_sigs=0, FSM=IDLE, report_valid=0, report_idx=0, report_count=0.
REQ-029 Reset asserted mid-stall or mid-REPORT SHALL abandon state on the next edge; no report survives reset.

Verification (THRESH=4, N_CH=2)
REQ-030 ch0 tvalid=1,tready=0 held 6 cycles -> axis_block_sigs=2'b01 after 4th edge; report_valid=1, report_idx=0 one edge later.
REQ-031 ch1 stall 3 cycles, one transfer cycle, stall 3 cycles -> axis_block_sigs stays 2'b00, report_valid never 1.
REQ-032 Both channels stall from same cycle -> axis_block_sigs=2'b11 together; single report with report_idx=0; report_count=1 after ready.
REQ-033 Block then stall removed before report_ready; ready raised 5 cycles later -> report_valid held until ready; FSM HOLD->IDLE next edge; report_count=1.
REQ-034 Reset pulsed while report_valid=1 -> next edge report_valid=0, report_count=0, axis_block_sigs=0.
REQ-035 255+2 accepted reports -> report_count saturates at 255.
